// File: rtl/uart_tx_serializer_if.sv
// Byte request handshake between the UART send controller and the TX serializer,
// carrying the frame format controls alongside the data byte.
interface uart_tx_serializer_if;
  logic        tx_req_i;
  logic [7:0]  tx_data_i;
  logic [31:0] baud_cnt_max_i;
  logic [1:0]  paribit_i;
  logic        stopbit_i;
  logic        tx_end_o;
  logic        tx_busy_o;

  modport master (
    output tx_req_i, tx_data_i, baud_cnt_max_i, paribit_i, stopbit_i,
    input  tx_end_o, tx_busy_o
  );

  modport slave (
    input  tx_req_i, tx_data_i, baud_cnt_max_i, paribit_i, stopbit_i,
    output tx_end_o, tx_busy_o
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits, then a one-cycle completion pulse.
module uart_tx_serializer (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  uart_tx_serializer_if.slave       bus,
  output logic                      uart_tx_o
);

  localparam int unsigned CntW  = 32;
  localparam int unsigned DataW = 8;
  localparam int unsigned IdxW  = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [1:0]        par_q, par_d;
  logic              stop_q, stop_d;
  logic              stop2_q, stop2_d;
  logic              line_d, end_d, busy_d;
  logic              bit_done;
  logic              par_en;

  assign bit_done = (cnt_q == n_q - CntW'(1));
  assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.tx_req_i) state_d = S_START;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA:   if (bit_done && (idx_q == IdxW'(7))) state_d = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done && (!stop_q || stop2_q)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame parameters are captured only on acceptance so mid-frame input changes are inert
  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    stop_d  = stop_q;
    stop2_d = stop2_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        stop2_d = 1'b0;
        if (bus.tx_req_i) begin
          data_d = bus.tx_data_i;
          par_d  = bus.paribit_i;
          stop_d = bus.stopbit_i;
          n_d    = (bus.baud_cnt_max_i == '0) ? CntW'(1) : bus.baud_cnt_max_i;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        idx_d   = '0;
        stop2_d = 1'b0;
      end
      default: begin
        cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        if ((state_q == S_DATA) && bit_done) idx_d = idx_q + IdxW'(1);
        if ((state_q == S_STOP) && bit_done) stop2_d = 1'b1;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered line leads with no extra latency
  always_comb begin
    line_d = 1'b1;
    end_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = data_d[idx_d];
      S_PARITY: line_d = (par_d == 2'b10) ? ^data_d : ~^data_d;
      S_DONE:   end_d  = 1'b1;
      default:  line_d = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q         <= '0;
      n_q           <= CntW'(1);
      idx_q         <= '0;
      data_q        <= '0;
      par_q         <= '0;
      stop_q        <= 1'b0;
      stop2_q       <= 1'b0;
      uart_tx_o     <= 1'b1;
      bus.tx_end_o  <= 1'b0;
      bus.tx_busy_o <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      par_q         <= par_d;
      stop_q        <= stop_d;
      stop2_q       <= stop2_d;
      uart_tx_o     <= line_d;
      bus.tx_end_o  <= end_d;
      bus.tx_busy_o <= busy_d;
    end
  end

endmodule
